// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU flag layout used by the result FIFO and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int FLAG_W   = 4;
    localparam int FLAG_ERR = 0;
    localparam int FLAG_NEG = 1;
    localparam int FLAG_POS = 2;
    localparam int FLAG_OVF = 3;

    typedef logic [FLAG_W-1:0] flag_t;

    // True when the flag word reports either error or overflow.
    function automatic logic flag_is_fault(input flag_t f);
        return f[FLAG_ERR] | f[FLAG_OVF];
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones; clear beats increment.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);

    logic w_at_max;

    assign w_at_max = &value;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc && !w_at_max) begin
            value <= value + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/alu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_fifo
// Description : Small FIFO buffering ALU results and flags, with err/overflow
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic [WIDTH-1:0]           i_result,
    input  logic [FLAG_W-1:0]          i_flag,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_result,
    output logic [FLAG_W-1:0]          o_flag,
    output logic [$clog2(DEPTH):0]     o_count,
    input  logic                       i_flush,
    input  logic                       i_clr,
    output logic [CNT_W-1:0]           o_err_cnt,
    output logic [CNT_W-1:0]           o_ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]  r_res_mem  [DEPTH];
    logic [FLAG_W-1:0] r_flag_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;

    logic w_wr;
    logic w_rd;
    logic w_err_inc;
    logic w_ovf_inc;

    assign o_ready = (r_count != c_FULL);
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    assign w_wr = i_valid & o_ready;
    assign w_rd = o_valid & i_ready;

    assign o_result = o_valid ? r_res_mem[r_rptr]  : '0;
    assign o_flag   = o_valid ? r_flag_mem[r_rptr] : '0;

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge i_clk) begin
        if (i_rstn && !i_flush && w_wr) begin
            r_res_mem[r_wptr]  <= i_result;
            r_flag_mem[r_wptr] <= i_flag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A write discarded by flush must not be counted either.
    assign w_err_inc = w_wr & ~i_flush & i_flag[FLAG_ERR];
    assign w_ovf_inc = w_wr & ~i_flush & i_flag[FLAG_OVF];

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (i_clk),
        .rstn  (i_rstn),
        .inc   (w_err_inc),
        .clr   (i_clr),
        .value (o_err_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_ovf_cnt (
        .clk   (i_clk),
        .rstn  (i_rstn),
        .inc   (w_ovf_inc),
        .clr   (i_clr),
        .value (o_ovf_cnt)
    );

endmodule : alu_result_fifo
`default_nettype wire
